timestamp_arbiter: RTL and testbench



---
 rtl/timestamp_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/timestamp_arbiter.sv | 138 +++++++++++++
 tb/tb_timestamp_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_pkg.sv
// Shared definitions for the timestamp capture arbiter: epoch width and gray-to-binary helper.
package timestamp_pkg;

    localparam int EPOCH_W    = 8;
    localparam int GRAY_MAX_W = 64;

    // Zero-extended inputs convert correctly because the leading zeros contribute nothing to the XOR chain.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int k = GRAY_MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the port after the last accepted grant; pointer starts at 0.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          accept_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] idx;
    int            j;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        j           = 0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            idx = IW'(j);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && gnt_valid_o) begin
            ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/timestamp_arbiter.sv
// Per-port timestamp capture with round-robin readout over AXI-Stream, plus gray counter prescaler.
// Optional epoch extension of the timestamp: define TIMESTAMP_ARBITER_EPOCH_EN.
module timestamp_arbiter
    import timestamp_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int WIDTH     = 32,
    parameter  int PRESCALE  = 1,
`ifdef TIMESTAMP_ARBITER_EPOCH_EN
    localparam int TW        = WIDTH + EPOCH_W,
`else
    localparam int TW        = WIDTH,
`endif
    localparam int IW        = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic                 cnt_enable,
    input  logic [WIDTH-1:0]     ts_gray,
    input  logic                 ts_carry,
    input  logic [NUM_PORTS-1:0] capture_req,
    output logic [TW-1:0]        m_axis_tdata,
    output logic [IW-1:0]        m_axis_tid,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [NUM_PORTS-1:0] overflow,
    input  logic [NUM_PORTS-1:0] overflow_clr
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt_q;
    logic            cnt_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
            cnt_en_q <= 1'b0;
        end else if (!run) begin
            ps_cnt_q <= '0;
            cnt_en_q <= 1'b0;
        end else if (ps_cnt_q == PS_W'(PRESCALE - 1)) begin
            ps_cnt_q <= '0;
            cnt_en_q <= 1'b1;
        end else begin
            ps_cnt_q <= ps_cnt_q + PS_W'(1);
            cnt_en_q <= 1'b0;
        end
    end

    assign cnt_enable = cnt_en_q;

    logic [TW-1:0]        slot_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] pend_q;
    logic [NUM_PORTS-1:0] ovf_q;
    logic [TW-1:0]        tdata_q;
    logic [IW-1:0]        tid_q;
    logic                 tvalid_q;

    logic [TW-1:0]        cap_word;
    logic [TW-1:0]        out_word;
    logic [TW-1:0]        slot_sel;
    logic                 out_free;
    logic [NUM_PORTS-1:0] gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_valid;
    logic [NUM_PORTS-1:0] take;
    logic [NUM_PORTS-1:0] cap_accept;
    logic [NUM_PORTS-1:0] ovf_set;

    assign out_free = !tvalid_q || m_axis_tready;

    rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (pend_q),
        .accept_i    (out_free),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // A slot being read out this cycle frees up in time to take a coincident capture.
    assign take       = gnt & {NUM_PORTS{out_free}};
    assign cap_accept = capture_req & (~pend_q | take);
    assign ovf_set    = capture_req & pend_q & ~take;
    assign slot_sel   = slot_q[gnt_idx];

`ifdef TIMESTAMP_ARBITER_EPOCH_EN
    logic [EPOCH_W-1:0] epoch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        epoch_q <= '0;
        else if (ts_carry) epoch_q <= epoch_q + EPOCH_W'(1);
    end

    // The carry edge belongs to the new epoch, so a capture on that edge sees the incremented value.
    assign cap_word = {epoch_q + EPOCH_W'(ts_carry), ts_gray};
    assign out_word = {slot_sel[TW-1:WIDTH],
                       WIDTH'(gray2bin(GRAY_MAX_W'(slot_sel[WIDTH-1:0])))};
`else
    logic unused_carry;
    assign unused_carry = ts_carry;
    assign cap_word     = ts_gray;
    assign out_word     = WIDTH'(gray2bin(GRAY_MAX_W'(slot_sel)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            ovf_q    <= '0;
            tdata_q  <= '0;
            tid_q    <= '0;
            tvalid_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) slot_q[i] <= '0;
        end else begin
            pend_q <= cap_accept | (pend_q & ~take);
            ovf_q  <= ovf_set | (ovf_q & ~overflow_clr);
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cap_accept[i]) slot_q[i] <= cap_word;
            end
            if (out_free && gnt_valid) begin
                tdata_q  <= out_word;
                tid_q    <= gnt_idx;
                tvalid_q <= 1'b1;
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tvalid = tvalid_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_timestamp_arbiter.sv
// Directed bench for timestamp_arbiter: vector table plus hand-written reset, round-robin and epoch sequences.
module tb_timestamp_arbiter;
    import timestamp_pkg::*;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int PS = 3;
`ifdef TIMESTAMP_ARBITER_EPOCH_EN
    localparam int TW = W + EPOCH_W;
`else
    localparam int TW = W;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          cnt_enable;
    logic [W-1:0]  ts_gray;
    logic          ts_carry;
    logic [NP-1:0] capture_req;
    logic [TW-1:0] m_axis_tdata;
    logic [1:0]    m_axis_tid;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [NP-1:0] overflow;
    logic [NP-1:0] overflow_clr;

    timestamp_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .PRESCALE(PS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .cnt_enable    (cnt_enable),
        .ts_gray       (ts_gray),
        .ts_carry      (ts_carry),
        .capture_req   (capture_req),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          run;
        logic [NP-1:0] cap;
        logic [W-1:0]  gray;
        logic          rdy;
        logic [NP-1:0] clr;
        logic          e_cnt;
        logic          e_valid;
        logic [1:0]    e_tid;
        logic [TW-1:0] e_data;
        logic [NP-1:0] e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [3:0] cap, input logic [31:0] gray,
                       input logic rdy, input logic [3:0] clr, input logic e_cnt,
                       input logic e_valid, input logic [1:0] e_tid,
                       input logic [31:0] e_data, input logic [3:0] e_ovf);
        vec_t v;
        v.run = r; v.cap = cap; v.gray = gray; v.rdy = rdy; v.clr = clr;
        v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_tid = e_tid;
        v.e_data = TW'(e_data); v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_cnt, input logic e_valid,
                         input logic [1:0] e_tid, input logic [TW-1:0] e_data,
                         input logic [NP-1:0] e_ovf);
        logic ok;
        n_vec++;
        ok = (cnt_enable === e_cnt) && (m_axis_tvalid === e_valid) && (overflow === e_ovf);
        if (e_valid) ok = ok && (m_axis_tid === e_tid) && (m_axis_tdata === e_data);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got cnt_en=%0b tvalid=%0b tid=%0d tdata=%h ovf=%b, want cnt_en=%0b tvalid=%0b tid=%0d tdata=%h ovf=%b",
                     name, cnt_enable, m_axis_tvalid, m_axis_tid, m_axis_tdata, overflow,
                     e_cnt, e_valid, e_tid, e_data, e_ovf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; ts_gray = '0; ts_carry = 1'b0;
        capture_req = '0; m_axis_tready = 1'b0; overflow_clr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        for (int k = 1; k <= 10; k++)
            add(1'b1, 4'b0000, 32'd0, 1'b0, 4'b0000, (k % 3 == 0), 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b1, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b1, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b1, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 32'd0, 4'b0000);
        // single capture from idle: gray 3 -> binary 2 on port 2
        add(1'b0, 4'b0100, 32'd3, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 32'd2, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        // backpressure and overflow on port 1
        add(1'b0, 4'b0010, 32'd5, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd6, 4'b0000);
        add(1'b0, 4'b0010, 32'd7, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd6, 4'b0000);
        add(1'b0, 4'b0010, 32'd9, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd6, 4'b0010);
        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd6, 4'b0010);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd5, 4'b0010);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        // overflow set coinciding with clear
        add(1'b0, 4'b0010, 32'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd1, 4'b0000);
        add(1'b0, 4'b0010, 32'd2, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd1, 4'b0000);
        add(1'b0, 4'b0010, 32'd3, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 32'd1, 4'b0010);
        add(1'b0, 4'b0000, 32'd0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 32'd1, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd3, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        // capture arriving on the same edge its slot is granted
        add(1'b0, 4'b0001, 32'd4, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
        add(1'b0, 4'b0001, 32'd6, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 32'd7, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 32'd4, 4'b0000);
        add(1'b0, 4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            run = vecs[i].run; capture_req = vecs[i].cap; ts_gray = vecs[i].gray;
            m_axis_tready = vecs[i].rdy; overflow_clr = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_valid,
                  vecs[i].e_tid, vecs[i].e_data, vecs[i].e_ovf);
        end
        run = 1'b0; capture_req = '0; overflow_clr = '0;

        // reset with a held beat and two pending slots; pointer is at 1 here
        m_axis_tready = 1'b0; capture_req = 4'b0111; ts_gray = 32'd8;
        tick(); check("rst_pre_cap", 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        capture_req = 4'b0000;
        tick(); check("rst_pre_grant", 1'b0, 1'b1, 2'd1, TW'(32'd15), 4'b0000);
        capture_req = 4'b0100;
        tick(); check("rst_pre_ovf", 1'b0, 1'b1, 2'd1, TW'(32'd15), 4'b0100);
        capture_req = 4'b0000;
        rst_n = 1'b0;
        #1 check("rst_async", 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        tick();
        rst_n = 1'b1; m_axis_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); check($sformatf("rst_idle%0d", k), 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        end
        // pointer must restart at 0: port 1 ahead of port 2
        capture_req = 4'b0110; ts_gray = 32'd3;
        tick(); check("post_rst_cap", 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        capture_req = 4'b0000;
        tick(); check("post_rst_b0", 1'b0, 1'b1, 2'd1, TW'(32'd2), 4'b0000);
        tick(); check("post_rst_b1", 1'b0, 1'b1, 2'd2, TW'(32'd2), 4'b0000);
        capture_req = 4'b1000; ts_gray = 32'd1;
        tick(); check("post_rst_p3cap", 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        capture_req = 4'b0000;
        tick(); check("post_rst_p3", 1'b0, 1'b1, 2'd3, TW'(32'd1), 4'b0000);

        // all ports at once, twice; pointer sits at 0 after the port 3 grant
        for (int rep = 0; rep < 2; rep++) begin
            capture_req = 4'b1111; ts_gray = 32'd5;
            tick(); check($sformatf("rr%0d_cap", rep), 1'b0, 1'b0, 2'd0, '0, 4'b0000);
            capture_req = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                tick();
                check($sformatf("rr%0d_beat%0d", rep, k), 1'b0, 1'b1, 2'(k), TW'(32'd6), 4'b0000);
            end
            tick(); check($sformatf("rr%0d_idle", rep), 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        end

`ifdef TIMESTAMP_ARBITER_EPOCH_EN
        ts_carry = 1'b1;
        repeat (3) tick();
        capture_req = 4'b0001; ts_gray = 32'd0;
        tick(); check("epoch_cap", 1'b0, 1'b0, 2'd0, '0, 4'b0000);
        ts_carry = 1'b0; capture_req = 4'b0000;
        tick(); check("epoch_beat", 1'b0, 1'b1, 2'd0, {8'd4, 32'd0}, 4'b0000);
        tick(); check("epoch_idle", 1'b0, 1'b0, 2'd0, '0, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
